dual_rail_rx: RTL and testbench
===============================

Name: dual_rail_rx

Overview:
- Receive side of the team's complementary-output (true/complement rail) flop interface.
- Accepts WIDTH-bit beats on a true rail and a complement rail, and checks per bit that in_t == ~in_f.
- Forwards the true-rail data one cycle later with a per-beat error flag.
- Tracks link health with a NORMAL/SUSPECT/FAULT state machine, a saturating error counter and first-error syndrome capture.

Parameters:
- WIDTH, 8, data width of each rail.
- ERR_THRESH, 3, consecutive bad beats (from NORMAL) needed to enter FAULT; legal range 1..15.
- RECOVER_CNT, 4, consecutive good beats in FAULT needed to return to NORMAL; legal range 1..15.
- CNT_W, 8, width of err_count.

Ports:
- clk  input  1  clock; all logic on posedge.
- rstn  input  1  synchronous, active-low reset.
- in_valid  input  1  beat present on in_t/in_f this cycle.
- in_t  input  WIDTH  true rail.
- in_f  input  WIDTH  complement rail.
- clr_err  input  1  clears err_count, syndrome, syn_vld; FSM unaffected.
- out_valid  output  1  registered beat valid.
- out_data  output  WIDTH  registered in_t of the accepted beat.
- out_err  output  1  registered per-beat rail-mismatch flag.
- syndrome  output  WIDTH  mismatch mask (in_t ~^ in_f) of first bad beat since reset/clear.
- syn_vld  output  1  syndrome holds a captured value.
- err_count  output  CNT_W  bad beats seen since reset/clear; saturating.
- fault  output  1  high while state == FAULT.
- state  output  2  0=NORMAL, 1=SUSPECT, 2=FAULT; encoding 3 is unused.

Behaviour:
- Reset (rstn=0 at posedge): all outputs 0; state NORMAL; internal bad_run and good_run counters 0. Reset takes priority over every other input, including mid-FAULT.
- Beat classification:
  - bad = in_valid & |(in_t ~^ in_f).
  - good = in_valid & ~bad.
  - Cycles with in_valid=0 change nothing except clearing out_valid.
- Latency: 1 cycle.
  - out_valid <= in_valid & (state != FAULT), using the state before this edge's update.
  - out_data <= in_t and out_err <= bad whenever in_valid; both hold otherwise.
  - Beats accepted while in FAULT, including the beat that completes recovery, are dropped (out_valid=0).
- FSM (evaluated on valid beats only):
  - NORMAL:
    - bad: bad_run <= 1; go to FAULT if ERR_THRESH == 1, else SUSPECT.
    - good: stay.
  - SUSPECT:
    - bad: bad_run++; go to FAULT when bad_run+1 == ERR_THRESH.
    - good: go to NORMAL; bad_run <= 0.
  - FAULT:
    - good: good_run++; go to NORMAL with good_run <= 0 and bad_run <= 0 when good_run+1 == RECOVER_CNT.
    - bad: good_run <= 0; stay.
- fault = (state == FAULT), registered with state.
- err_count: +1 on every bad beat in any state; holds at 2^CNT_W-1 (no wrap).
- syndrome: on a bad beat with syn_vld=0, syndrome <= in_t ~^ in_f and syn_vld <= 1. Later bad beats do not overwrite it.
- clr_err:
  - Clears err_count, syndrome and syn_vld.
  - If the same cycle carries a bad beat, the clear applies first: err_count <= 1, syndrome captures the current beat, syn_vld <= 1.
  - State, bad_run and good_run are not affected.
- Invariant checked by an embedded immediate assertion on each posedge when rstn=1: state != 3, and fault == (state == 2).

Test Plan:
- Clean traffic: reset, then 4 beats in_t=8'hA5,in_f=8'h5A -> out_valid=1 one cycle after each beat, out_data=8'hA5, out_err=0, state=0, err_count=0.
- Single glitch: beat in_t=8'hA5,in_f=8'h5B (bit0 mismatch) followed by a good beat -> out_err=1, state NORMAL->SUSPECT->NORMAL, syndrome=8'h01, syn_vld=1, err_count=1.
- Fault entry and recovery (ERR_THRESH=3, RECOVER_CNT=4):
  - 3 bad beats -> state 0->1->1->2, fault=1 after the 3rd.
  - 3 good beats, 1 bad, then 4 good -> good_run restarts after the bad beat; state=0 only after the 4th good.
  - All 8 beats dropped (out_valid=0); err_count=4.
- Saturation (CNT_W=2): 5 bad beats -> err_count 1,2,3,3,3.
- Clear collision: assert clr_err on the same cycle as a bad beat with in_t=8'hF0,in_f=8'hF0 -> err_count=1, syndrome=8'hFF, syn_vld=1, state unchanged by the clear.
- Reset mid-FAULT: while fault=1, pulse rstn=0 for one clock -> next cycle all outputs 0, state=0. A following good beat produces out_valid=1.

Source files
------------

// File: rtl/dual_rail_rx_if.sv
// Beat and status bundle for the dual-rail receiver.
// master drives the rails and the clear strobe; slave is the receiver itself.
interface dual_rail_rx_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic [WIDTH-1:0] in_t;
    logic [WIDTH-1:0] in_f;
    logic             clr_err;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_err;
    logic [WIDTH-1:0] syndrome;
    logic             syn_vld;
    logic [CNT_W-1:0] err_count;
    logic             fault;
    logic [1:0]       state;

    modport master (
        output in_valid, in_t, in_f, clr_err,
        input  out_valid, out_data, out_err, syndrome, syn_vld, err_count, fault, state
    );

    modport slave (
        input  in_valid, in_t, in_f, clr_err,
        output out_valid, out_data, out_err, syndrome, syn_vld, err_count, fault, state
    );
endinterface

// File: rtl/dual_rail_rx.sv
// Dual-rail (true/complement) receiver: per-bit rail check, 1-cycle forwarding,
// link-health FSM, saturating error counter and first-error syndrome capture.
//
// state   | meaning
// NORMAL  | link healthy, beats forwarded
// SUSPECT | bad beats seen, below ERR_THRESH in a row; beats still forwarded
// FAULT   | link faulted; beats dropped until RECOVER_CNT good beats in a row
module dual_rail_rx #(
    parameter int WIDTH       = 8,
    parameter int ERR_THRESH  = 3,
    parameter int RECOVER_CNT = 4,
    parameter int CNT_W       = 8
) (
    input  logic           clk,
    input  logic           rstn,
    dual_rail_rx_if.slave  bus
);
    typedef enum logic [1:0] {
        NORMAL  = 2'd0,
        SUSPECT = 2'd1,
        FAULT   = 2'd2
    } state_t;

    localparam logic [3:0] THRESH  = 4'(ERR_THRESH);
    localparam logic [3:0] RECOVER = 4'(RECOVER_CNT);

    state_t           st;
    logic [3:0]       bad_run;
    logic [3:0]       good_run;
    logic [WIDTH-1:0] mis;
    logic             bad;
    logic             good;

    // A set bit in mis marks a position where the rails agree, i.e. a broken pair.
    assign mis  = bus.in_t ~^ bus.in_f;
    assign bad  = bus.in_valid & (|mis);
    assign good = bus.in_valid & ~bad;
    assign bus.state = st;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            st            <= NORMAL;
            bad_run       <= '0;
            good_run      <= '0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_err   <= 1'b0;
            bus.syndrome  <= '0;
            bus.syn_vld   <= 1'b0;
            bus.err_count <= '0;
            bus.fault     <= 1'b0;
        end else begin
            bus.out_valid <= bus.in_valid && (st != FAULT);
            if (bus.in_valid) begin
                bus.out_data <= bus.in_t;
                bus.out_err  <= bad;
            end

            // Clear first so a colliding bad beat is counted and captured afresh.
            if (bus.clr_err) begin
                bus.err_count <= '0;
                bus.syndrome  <= '0;
                bus.syn_vld   <= 1'b0;
            end
            if (bad) begin
                if (bus.clr_err || !bus.syn_vld) begin
                    bus.syndrome <= mis;
                    bus.syn_vld  <= 1'b1;
                end
                if (bus.clr_err)
                    bus.err_count <= CNT_W'(1);
                else if (bus.err_count != {CNT_W{1'b1}})
                    bus.err_count <= bus.err_count + CNT_W'(1);
            end

            case (st)
                NORMAL: begin
                    if (bad) begin
                        bad_run <= 4'd1;
                        if (THRESH == 4'd1) begin
                            st        <= FAULT;
                            bus.fault <= 1'b1;
                        end else begin
                            st <= SUSPECT;
                        end
                    end
                end
                SUSPECT: begin
                    if (bad) begin
                        bad_run <= bad_run + 4'd1;
                        if (bad_run + 4'd1 == THRESH) begin
                            st        <= FAULT;
                            bus.fault <= 1'b1;
                        end
                    end else if (good) begin
                        st      <= NORMAL;
                        bad_run <= '0;
                    end
                end
                FAULT: begin
                    if (good) begin
                        if (good_run + 4'd1 == RECOVER) begin
                            st        <= NORMAL;
                            bus.fault <= 1'b0;
                            good_run  <= '0;
                            bad_run   <= '0;
                        end else begin
                            good_run <= good_run + 4'd1;
                        end
                    end else if (bad) begin
                        good_run <= '0;
                    end
                end
                default: begin
                    st        <= NORMAL;
                    bus.fault <= 1'b0;
                end
            endcase
        end
    end

    always @(posedge clk) begin
        if (rstn)
            assert (2'(st) != 2'd3 && bus.fault == (st == FAULT));
    end
endmodule

// File: tb/tb_dual_rail_rx.sv
// Self-checking bench for dual_rail_rx: directed scenarios plus a randomized run
// against a behavioural model of the link-health rules.
module tb_dual_rail_rx;
    localparam int ERR_THRESH  = 3;
    localparam int RECOVER_CNT = 4;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    dual_rail_rx_if #(.WIDTH(8), .CNT_W(8)) bus ();
    dual_rail_rx_if #(.WIDTH(8), .CNT_W(2)) bus2 ();

    dual_rail_rx #(.WIDTH(8), .ERR_THRESH(ERR_THRESH), .RECOVER_CNT(RECOVER_CNT), .CNT_W(8)) dut (
        .clk(clk), .rstn(rstn), .bus(bus)
    );
    dual_rail_rx #(.WIDTH(8), .ERR_THRESH(ERR_THRESH), .RECOVER_CNT(RECOVER_CNT), .CNT_W(2)) dut_sat (
        .clk(clk), .rstn(rstn), .bus(bus2)
    );

    // Reference model: link state, run lengths and sticky error bookkeeping.
    logic [1:0] m_state;
    int         m_bad, m_good;
    logic [7:0] m_cnt, m_syn, m_od;
    logic       m_synv, m_ov, m_oe;

    function automatic void model_reset();
        m_state = 2'd0; m_bad = 0; m_good = 0;
        m_cnt = '0; m_syn = '0; m_od = '0;
        m_synv = 1'b0; m_ov = 1'b0; m_oe = 1'b0;
    endfunction

    function automatic void model_step(input logic v, input logic [7:0] t, input logic [7:0] f, input logic c);
        logic [7:0] broken;
        logic       is_bad;
        broken = ~(t ^ f);
        is_bad = v && (broken != 8'h00);
        m_ov = v && (m_state != 2'd2);
        if (v) begin
            m_od = t;
            m_oe = is_bad;
        end
        if (c) begin
            m_cnt = 8'h00; m_syn = 8'h00; m_synv = 1'b0;
        end
        if (is_bad) begin
            if (!m_synv) begin
                m_syn = broken; m_synv = 1'b1;
            end
            if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
        end
        if (v) begin
            if (m_state == 2'd2) begin
                if (is_bad) m_good = 0;
                else begin
                    m_good = m_good + 1;
                    if (m_good == RECOVER_CNT) begin
                        m_state = 2'd0; m_good = 0; m_bad = 0;
                    end
                end
            end else if (is_bad) begin
                m_bad = m_bad + 1;
                m_state = (m_bad >= ERR_THRESH) ? 2'd2 : 2'd1;
            end else begin
                m_bad = 0; m_state = 2'd0;
            end
        end
    endfunction

    task automatic step(input logic v, input logic [7:0] t, input logic [7:0] f, input logic c);
        bus.in_valid = v; bus.in_t = t; bus.in_f = f; bus.clr_err = c;
        @(posedge clk);
        if (rstn) model_step(v, t, f, c);
        else model_reset();
        #1;
        bus.in_valid = 1'b0; bus.clr_err = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        step(1'b1, 8'hFF, 8'hFF, 1'b0);
        checks++;
        if ({bus.out_valid, bus.out_data, bus.out_err, bus.syndrome, bus.syn_vld, bus.err_count, bus.fault, bus.state} !== 36'h0) begin
            errors++;
            $display("FAIL reset_outputs: got ov=%0b od=%h oe=%0b syn=%h sv=%0b cnt=%0d f=%0b st=%0d, required all 0",
                     bus.out_valid, bus.out_data, bus.out_err, bus.syndrome, bus.syn_vld, bus.err_count, bus.fault, bus.state);
        end
        checks++;
        if (bus2.err_count !== 2'd0) begin
            errors++; $display("FAIL reset_sat_count: got %0d required 0", bus2.err_count);
        end
        rstn = 1'b1;
    endtask

    task automatic test_clean();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 8'hA5, 8'h5A, 1'b0);
            checks++;
            if ({bus.out_valid, bus.out_data, bus.out_err, bus.state, bus.err_count} !== {1'b1, 8'hA5, 1'b0, 2'd0, 8'd0}) begin
                errors++;
                $display("FAIL clean_beat%0d: got ov=%0b od=%h oe=%0b st=%0d cnt=%0d, required 1 a5 0 0 0",
                         i, bus.out_valid, bus.out_data, bus.out_err, bus.state, bus.err_count);
            end
        end
        step(1'b0, 8'h00, 8'h00, 1'b0);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL idle_valid: got %0b required 0", bus.out_valid);
        end
    endtask

    task automatic test_glitch();
        step(1'b1, 8'hA5, 8'h5B, 1'b0);
        checks++;
        if ({bus.out_valid, bus.out_err, bus.state, bus.syndrome, bus.syn_vld, bus.err_count} !== {1'b1, 1'b1, 2'd1, 8'h01, 1'b1, 8'd1}) begin
            errors++;
            $display("FAIL glitch_bad: got ov=%0b oe=%0b st=%0d syn=%h sv=%0b cnt=%0d, required 1 1 1 01 1 1",
                     bus.out_valid, bus.out_err, bus.state, bus.syndrome, bus.syn_vld, bus.err_count);
        end
        step(1'b1, 8'h3C, 8'hC3, 1'b0);
        checks++;
        if ({bus.out_valid, bus.out_err, bus.out_data, bus.state, bus.syndrome, bus.err_count} !== {1'b1, 1'b0, 8'h3C, 2'd0, 8'h01, 8'd1}) begin
            errors++;
            $display("FAIL glitch_recover: got ov=%0b oe=%0b od=%h st=%0d syn=%h cnt=%0d, required 1 0 3c 0 01 1",
                     bus.out_valid, bus.out_err, bus.out_data, bus.state, bus.syndrome, bus.err_count);
        end
    endtask

    task automatic test_fault_recovery();
        logic [1:0] exp_st [3] = '{2'd1, 2'd1, 2'd2};
        logic       seq_v  [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [1:0] seq_st [8] = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd0};
        step(1'b0, 8'h00, 8'h00, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 8'h11, 8'h11, 1'b0);
            checks++;
            if ({bus.state, bus.fault} !== {exp_st[i], (i == 2)}) begin
                errors++;
                $display("FAIL fault_entry%0d: got st=%0d f=%0b required st=%0d f=%0b", i, bus.state, bus.fault, exp_st[i], (i == 2));
            end
        end
        // seq_v marks good beats; the fourth beat is the bad one that restarts recovery.
        for (int i = 0; i < 8; i++) begin
            if (seq_v[i]) step(1'b1, 8'h69, 8'h96, 1'b0);
            else          step(1'b1, 8'h69, 8'h69, 1'b0);
            checks++;
            if ({bus.out_valid, bus.state, bus.fault} !== {1'b0, seq_st[i], seq_st[i] == 2'd2}) begin
                errors++;
                $display("FAIL recover_beat%0d: got ov=%0b st=%0d f=%0b required ov=0 st=%0d", i, bus.out_valid, bus.state, bus.fault, seq_st[i]);
            end
        end
        checks++;
        if (bus.err_count !== 8'd4) begin
            errors++; $display("FAIL recover_count: got %0d required 4", bus.err_count);
        end
    endtask

    task automatic test_saturation();
        logic [1:0] exp_cnt [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        bus2.in_valid = 1'b1; bus2.in_t = 8'h0F; bus2.in_f = 8'h0F; bus2.clr_err = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (bus2.err_count !== exp_cnt[i]) begin
                errors++; $display("FAIL saturate%0d: got %0d required %0d", i, bus2.err_count, exp_cnt[i]);
            end
        end
        bus2.in_valid = 1'b0;
    endtask

    task automatic test_clear_collision();
        logic [1:0] st_before;
        step(1'b1, 8'h80, 8'h7E, 1'b0);
        st_before = bus.state;
        step(1'b1, 8'hF0, 8'hF0, 1'b1);
        checks++;
        if ({bus.err_count, bus.syndrome, bus.syn_vld} !== {8'd1, 8'hFF, 1'b1}) begin
            errors++;
            $display("FAIL clear_collision: got cnt=%0d syn=%h sv=%0b required 1 ff 1", bus.err_count, bus.syndrome, bus.syn_vld);
        end
        checks++;
        if ({st_before, bus.state} !== {2'd1, 2'd1}) begin
            errors++; $display("FAIL clear_state: got before=%0d after=%0d required 1 1", st_before, bus.state);
        end
        step(1'b1, 8'h12, 8'hED, 1'b0);
        checks++;
        if (bus.state !== 2'd0) begin
            errors++; $display("FAIL clear_state_good: got %0d required 0", bus.state);
        end
    endtask

    task automatic test_reset_mid_fault();
        for (int i = 0; i < 3; i++) step(1'b1, 8'h00, 8'h00, 1'b0);
        checks++;
        if (bus.fault !== 1'b1) begin
            errors++; $display("FAIL pre_reset_fault: got %0b required 1", bus.fault);
        end
        rstn = 1'b0;
        step(1'b1, 8'h00, 8'h00, 1'b0);
        rstn = 1'b1;
        checks++;
        if ({bus.out_valid, bus.out_data, bus.out_err, bus.syndrome, bus.syn_vld, bus.err_count, bus.fault, bus.state} !== 36'h0) begin
            errors++;
            $display("FAIL mid_fault_reset: got ov=%0b od=%h oe=%0b syn=%h sv=%0b cnt=%0d f=%0b st=%0d, required all 0",
                     bus.out_valid, bus.out_data, bus.out_err, bus.syndrome, bus.syn_vld, bus.err_count, bus.fault, bus.state);
        end
        step(1'b1, 8'hA5, 8'h5A, 1'b0);
        checks++;
        if ({bus.out_valid, bus.out_data, bus.state} !== {1'b1, 8'hA5, 2'd0}) begin
            errors++; $display("FAIL post_reset_beat: got ov=%0b od=%h st=%0d required 1 a5 0", bus.out_valid, bus.out_data, bus.state);
        end
    endtask

    task automatic test_random();
        logic [7:0] t, f;
        logic       v, c;
        int         err_pct;
        for (int i = 0; i < 400; i++) begin
            err_pct = ((i / 50) % 2 == 0) ? 15 : 65;
            t = 8'($urandom);
            f = ~t;
            if ($urandom_range(0, 99) < err_pct) f = f ^ (8'h01 << $urandom_range(0, 7));
            v = ($urandom_range(0, 4) != 0);
            c = ($urandom_range(0, 29) == 0);
            step(v, t, f, c);
            checks++;
            if ({bus.out_valid, bus.out_data, bus.out_err, bus.syndrome, bus.syn_vld, bus.err_count, bus.fault, bus.state} !==
                {m_ov, m_od, m_oe, m_syn, m_synv, m_cnt, (m_state == 2'd2), m_state}) begin
                errors++;
                $display("FAIL random%0d: got ov=%0b od=%h oe=%0b syn=%h sv=%0b cnt=%0d f=%0b st=%0d required ov=%0b od=%h oe=%0b syn=%h sv=%0b cnt=%0d st=%0d",
                         i, bus.out_valid, bus.out_data, bus.out_err, bus.syndrome, bus.syn_vld, bus.err_count, bus.fault, bus.state,
                         m_ov, m_od, m_oe, m_syn, m_synv, m_cnt, m_state);
            end
        end
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.in_t = '0; bus.in_f = '0; bus.clr_err = 1'b0;
        bus2.in_valid = 1'b0; bus2.in_t = '0; bus2.in_f = '0; bus2.clr_err = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_clean();
        test_glitch();
        test_fault_recovery();
        test_saturation();
        test_clear_collision();
        test_reset_mid_fault();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
